// File: rtl/lfsr_prbs_lock_check_pkg.sv
// Shared definitions for the PRBS lock checker: modes, tap pairs, lock states.
package lfsr_prbs_lock_check_pkg;

  localparam int HIST_W = 31;

  typedef enum logic [2:0] {
    MODE_PRBS7  = 3'd0,
    MODE_PRBS9  = 3'd1,
    MODE_PRBS15 = 3'd2,
    MODE_PRBS23 = 3'd3,
    MODE_PRBS31 = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] n1;
    logic [4:0] n2;
  } taps_t;

  // Encodings 5..7 alias PRBS31.
  function automatic taps_t prbs_taps(input logic [2:0] mode);
    taps_t t;
    case (mode)
      MODE_PRBS7:  t = '{n1: 5'd7,  n2: 5'd6};
      MODE_PRBS9:  t = '{n1: 5'd9,  n2: 5'd5};
      MODE_PRBS15: t = '{n1: 5'd15, n2: 5'd14};
      MODE_PRBS23: t = '{n1: 5'd23, n2: 5'd18};
      default:     t = '{n1: 5'd31, n2: 5'd28};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_prbs_lock_check_if.sv
// Data/error stream bundle between the receive path and the PRBS checker.
interface lfsr_prbs_lock_check_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic [DATA_WIDTH-1:0] error_out;
  logic                  error_valid;

  modport master (
    output data_in, data_in_valid,
    input  error_out, error_valid
  );

  modport slave (
    input  data_in, data_in_valid,
    output error_out, error_valid
  );
endinterface

// File: rtl/lfsr_prbs_lock_check_predict.sv
// Combinational self-synchronising predictor: checks one word bit by bit,
// feeding each received bit back into the history for the bits after it.
module lfsr_prbs_predict
  import lfsr_prbs_lock_check_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [HIST_W-1:0]     history,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [2:0]            mode,
  output logic [DATA_WIDTH-1:0] err_mask,
  output logic [HIST_W-1:0]     hist_next
);
  taps_t             taps;
  logic [HIST_W-1:0] h;

  always_comb begin
    taps     = prbs_taps(mode);
    h        = history;
    err_mask = '0;
    // MSB is first in time; h[0] is always the most recent bit.
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      err_mask[i] = data_in[i] ^ h[taps.n1 - 5'd1] ^ h[taps.n2 - 5'd1];
      h           = {h[HIST_W-2:0], data_in[i]};
    end
    hist_next = h;
  end
endmodule

// File: rtl/lfsr_prbs_lock_check.sv
// PRBS7..31 receive checker: fill/hunt/locked FSM, per-bit error mask and
// saturating error/word counters.
module lfsr_prbs_lock_check
  import lfsr_prbs_lock_check_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_ERRORS = 4,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             mode,
  input  logic                   count_clear,
  lfsr_prbs_lock_check_if.slave  bus,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [COUNT_WIDTH-1:0] word_count
);
  localparam int FILL_WORDS = (HIST_W + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int CLW        = $clog2(LOCK_COUNT + 1);
  localparam int BDW        = $clog2(UNLOCK_ERRORS + 1);
  localparam int PW         = $clog2(DATA_WIDTH + 1);
  localparam int SW         = COUNT_WIDTH + PW;

  localparam logic [4:0]             FILL_LAST   = 5'(FILL_WORDS - 1);
  localparam logic [CLW-1:0]         LOCK_LAST   = CLW'(LOCK_COUNT - 1);
  localparam logic [BDW-1:0]         UNLOCK_LAST = BDW'(UNLOCK_ERRORS - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;

  state_e                  state_q, state_d, eff_st;
  logic [2:0]              mode_q;
  logic [HIST_W-1:0]       hist_q, hist_nxt;
  logic [DATA_WIDTH-1:0]   err_mask;
  logic [4:0]              fill_q, fill_d;
  logic [CLW-1:0]          clean_q, clean_d;
  logic [BDW-1:0]          bad_q, bad_d;
  logic                    vld, mode_chg, word_err, count_en;
  logic [PW-1:0]           pop;
  logic [SW-1:0]           ec_sum, wc_sum;
  logic [COUNT_WIDTH-1:0]  ec_nxt, wc_nxt;

  assign vld      = bus.data_in_valid;
  assign mode_chg = (mode != mode_q);
  assign word_err = |err_mask;
  assign locked   = (state_q == LOCKED);

  // Prediction always uses the live mode so a word arriving with a mode
  // change is already checked under the new polynomial.
  lfsr_prbs_predict #(.DATA_WIDTH(DATA_WIDTH)) u_predict (
    .history  (hist_q),
    .data_in  (bus.data_in),
    .mode     (mode),
    .err_mask (err_mask),
    .hist_next(hist_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      clean_q <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      clean_q <= clean_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    eff_st  = mode_chg ? FILL : state_q;
    state_d = eff_st;
    fill_d  = mode_chg ? '0 : fill_q;
    clean_d = mode_chg ? '0 : clean_q;
    bad_d   = mode_chg ? '0 : bad_q;
    if (vld) begin
      unique case (eff_st)
        FILL: begin
          if (fill_d == FILL_LAST) begin
            state_d = HUNT;
            fill_d  = '0;
            clean_d = '0;
          end else begin
            fill_d = fill_d + 1'b1;
          end
        end
        HUNT: begin
          if (word_err) begin
            clean_d = '0;
          end else if (clean_d == LOCK_LAST) begin
            state_d = LOCKED;
            clean_d = '0;
            bad_d   = '0;
          end else begin
            clean_d = clean_d + 1'b1;
          end
        end
        LOCKED: begin
          if (!word_err) begin
            bad_d = '0;
          end else if (bad_d == UNLOCK_LAST) begin
            state_d = HUNT;
            bad_d   = '0;
            clean_d = '0;
          end else begin
            bad_d = bad_d + 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
    count_en = vld && (eff_st == LOCKED);
  end

  // Saturating counter arithmetic, done one bit wider than any increment.
  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pop = pop + PW'(err_mask[i]);
    ec_sum = SW'(error_count) + SW'(pop);
    wc_sum = SW'(word_count) + SW'(1);
    ec_nxt = (ec_sum > SW'(CNT_MAX)) ? CNT_MAX : ec_sum[COUNT_WIDTH-1:0];
    wc_nxt = (wc_sum > SW'(CNT_MAX)) ? CNT_MAX : wc_sum[COUNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q          <= '0;
      hist_q          <= '0;
      bus.error_out   <= '0;
      bus.error_valid <= 1'b0;
      error_count     <= '0;
      word_count      <= '0;
    end else begin
      mode_q          <= mode;
      bus.error_valid <= vld;
      if (vld) begin
        hist_q        <= hist_nxt;
        bus.error_out <= (eff_st == FILL) ? '0 : err_mask;
      end
      if (count_clear) begin
        error_count <= '0;
        word_count  <= '0;
      end else if (count_en) begin
        error_count <= ec_nxt;
        word_count  <= wc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_lfsr_prbs_lock_check.sv
// Bench for lfsr_prbs_lock_check: a 32-bit-counter and a 4-bit-counter
// instance see the same stream and are compared against a bit-level model.
module tb_lfsr_prbs_lock_check;
  localparam int DW    = 8;
  localparam int FILLW = 4;

  logic       clk = 1'b0;
  logic       rst, count_clear;
  logic [2:0] mode;
  logic       locked0, locked1;
  logic [31:0] ec0, wc0;
  logic [3:0]  ec1, wc1;

  always #5 clk = ~clk;

  lfsr_prbs_lock_check_if #(.DATA_WIDTH(DW)) if0 ();
  lfsr_prbs_lock_check_if #(.DATA_WIDTH(DW)) if1 ();

  lfsr_prbs_lock_check #(.DATA_WIDTH(DW), .LOCK_COUNT(16), .UNLOCK_ERRORS(4), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mode(mode), .count_clear(count_clear), .bus(if0),
    .locked(locked0), .error_count(ec0), .word_count(wc0));

  lfsr_prbs_lock_check #(.DATA_WIDTH(DW), .LOCK_COUNT(16), .UNLOCK_ERRORS(4), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .count_clear(count_clear), .bus(if1),
    .locked(locked1), .error_count(ec1), .word_count(wc1));

  int tests = 0, fails = 0;

  // Reference model: received-bit history, fill/lock bookkeeping, unbounded counts.
  bit         mh[$];
  logic [2:0] m_mode;
  int         m_fill_left, m_run;
  bit         m_locked;
  longint     m_errs, m_words;
  logic [7:0] exp_eo;
  bit         exp_ev;

  // Generator: bit queue, newest at the back.
  bit         gq[$];
  logic [2:0] g_mode;

  function automatic void taps_of(input logic [2:0] md, output int n1, output int n2);
    case (md)
      3'd0:    begin n1 = 7;  n2 = 6;  end
      3'd1:    begin n1 = 9;  n2 = 5;  end
      3'd2:    begin n1 = 15; n2 = 14; end
      3'd3:    begin n1 = 23; n2 = 18; end
      default: begin n1 = 31; n2 = 28; end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mh.delete();
    for (int i = 0; i < 31; i++) mh.push_back(1'b0);
    m_mode = 3'd0; m_fill_left = FILLW; m_run = 0; m_locked = 1'b0;
    m_errs = 0; m_words = 0; exp_eo = '0; exp_ev = 1'b0;
  endfunction

  function automatic void set_mode(input logic [2:0] md);
    int n1, n2;
    mode = md; g_mode = md;
    taps_of(md, n1, n2);
    gq.delete();
    for (int i = 0; i < n1; i++) gq.push_back(1'b1);
  endfunction

  function automatic logic [7:0] gen_word();
    int n1, n2;
    logic [7:0] w;
    bit b;
    taps_of(g_mode, n1, n2);
    for (int i = 7; i >= 0; i--) begin
      b = gq[gq.size() - n1] ^ gq[gq.size() - n2];
      w[i] = b;
      gq.push_back(b);
      if (gq.size() > 31) void'(gq.pop_front());
    end
    return w;
  endfunction

  task automatic step(input logic [7:0] d, input bit v, input bit clr, input bit r);
    int n1, n2;
    logic [7:0] mask;
    bit cnt_it, p;
    if0.data_in = d; if1.data_in = d;
    if0.data_in_valid = v; if1.data_in_valid = v;
    count_clear = clr; rst = r;
    if (r) model_reset();
    else begin
      if (mode != m_mode) begin m_fill_left = FILLW; m_locked = 1'b0; m_run = 0; end
      m_mode = mode;
      exp_ev = v;
      if (v) begin
        cnt_it = m_locked;
        taps_of(mode, n1, n2);
        for (int i = DW - 1; i >= 0; i--) begin
          p = mh[31 - n1] ^ mh[31 - n2];
          mask[i] = d[i] ^ p;
          mh.push_back(d[i]);
          void'(mh.pop_front());
        end
        if (m_fill_left > 0) begin
          m_fill_left--; exp_eo = '0;
        end else begin
          exp_eo = mask;
          if (!m_locked) begin
            m_run = (mask == 0) ? m_run + 1 : 0;
            if (m_run == 16) begin m_locked = 1'b1; m_run = 0; end
          end else begin
            m_run = (mask != 0) ? m_run + 1 : 0;
            if (m_run == 4) begin m_locked = 1'b0; m_run = 0; end
          end
        end
        if (cnt_it) begin m_words++; m_errs += $countones(mask); end
      end
      if (clr) begin m_words = 0; m_errs = 0; end
    end
    @(posedge clk); #1;
    chk("error_valid", if0.error_valid, exp_ev);
    chk("error_valid_cw4", if1.error_valid, exp_ev);
    if (exp_ev || r) begin
      chk("error_out", if0.error_out, exp_eo);
      chk("error_out_cw4", if1.error_out, exp_eo);
    end
    chk("locked", locked0, m_locked);
    chk("locked_cw4", locked1, m_locked);
    chk("error_count", ec0, m_errs);
    chk("word_count", wc0, m_words);
    chk("error_count_cw4", ec1, (m_errs > 15) ? 15 : m_errs);
    chk("word_count_cw4", wc1, (m_words > 15) ? 15 : m_words);
  endtask

  task automatic send(input bit v, input logic [7:0] flip, input bit clr);
    logic [7:0] d;
    if (v) d = gen_word() ^ flip;
    else   d = 8'($urandom);
    step(d, v, clr, 1'b0);
  endtask

  task automatic do_reset();
    step(8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [2:0] mode;
    int         nwords;
    int         lock_word;
  } vec_t;

  vec_t vt[6];

  initial begin
    int first, pos[$];
    logic [31:0] ec_s, wc_s;
    rst = 1'b1; count_clear = 1'b0; mode = 3'd0;
    if0.data_in = '0; if1.data_in = '0; if0.data_in_valid = 1'b0; if1.data_in_valid = 1'b0;
    model_reset();

    // Lock-acquisition table: 4 fill words + 16 clean words for every mode.
    vt[0] = '{3'd0, 30, 20};
    vt[1] = '{3'd1, 30, 20};
    vt[2] = '{3'd2, 30, 20};
    vt[3] = '{3'd3, 30, 20};
    vt[4] = '{3'd7, 30, 20};
    vt[5] = '{3'd4, 30, 20};
    for (int t = 0; t < 6; t++) begin
      set_mode(vt[t].mode);
      do_reset();
      chk("reset_locked", locked0, 0);
      chk("reset_error_count", ec0, 0);
      first = -1;
      for (int w = 1; w <= vt[t].nwords; w++) begin
        send(1'b1, 8'h00, 1'b0);
        if (locked0 && first < 0) first = w;
      end
      chk("lock_word", first, vt[t].lock_word);
      chk("tbl_error_count", ec0, 0);
      chk("tbl_word_count", wc0, vt[t].nwords - vt[t].lock_word);
    end

    // Single flipped bit on PRBS31: errors at the flip, +28 and +31 bits.
    ec_s = ec0;
    pos.delete();
    for (int k = 0; k < 6; k++) begin
      send(1'b1, (k == 0) ? 8'h10 : 8'h00, 1'b0);
      for (int i = 7; i >= 0; i--) if (if0.error_out[i]) pos.push_back(k * 8 + (7 - i));
    end
    chk("flip_err_bits", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("flip_pos0", pos[0], 3);
      chk("flip_pos1", pos[1] - pos[0], 28);
      chk("flip_pos2", pos[2] - pos[0], 31);
    end
    chk("flip_count_delta", ec0 - ec_s, 3);
    chk("flip_still_locked", locked0, 1);

    // Four errored words drop lock; counters freeze; clean stream relocks.
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 8'h01, 1'b0);
      chk("unlock_seq", locked0, (k < 3) ? 1 : 0);
    end
    ec_s = ec0; wc_s = wc0;
    for (int k = 0; k < 8; k++) send(1'b1, 8'h00, 1'b0);
    chk("freeze_error_count", ec0, ec_s);
    chk("freeze_word_count", wc0, wc_s);
    for (int k = 0; k < 40 && !locked0; k++) send(1'b1, 8'h00, 1'b0);
    chk("relock", locked0, 1);

    // Mode change to PRBS7 while locked.
    set_mode(3'd0);
    ec_s = ec0; wc_s = wc0;
    send(1'b1, 8'h00, 1'b0);
    chk("modechg_locked", locked0, 0);
    for (int w = 2; w <= 20; w++) begin
      send(1'b1, 8'h00, 1'b0);
      if (w == 19) chk("modechg_lock19", locked0, 0);
      if (w == 20) chk("modechg_lock20", locked0, 1);
    end
    chk("modechg_error_count", ec0, ec_s);
    chk("modechg_word_count", wc0, wc_s);

    // count_clear beats a coincident errored locked word.
    send(1'b1, 8'h08, 1'b1);
    chk("clear_error_count", ec0, 0);
    chk("clear_word_count", wc0, 0);

    // Saturation of the 4-bit error counter.
    set_mode(3'd4);
    do_reset();
    for (int k = 0; k < 24; k++) send(1'b1, 8'h00, 1'b0);
    send(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) send(1'b1, 8'hFF, 1'b0);
    chk("sat_error_count_cw4", ec1, 15);
    for (int k = 0; k < 5; k++) send(1'b1, 8'h00, 1'b0);
    chk("sat_hold_cw4", ec1, 15);

    // Reset mid-stream while locked; FILL restarts.
    set_mode(3'd4);
    do_reset();
    for (int k = 0; k < 25; k++) send(1'b1, 8'h00, 1'b0);
    chk("pre_rst_locked", locked0, 1);
    step(gen_word(), 1'b1, 1'b0, 1'b1);
    chk("rst_locked", locked0, 0);
    chk("rst_error_valid", if0.error_valid, 0);
    chk("rst_error_count", ec0, 0);
    chk("rst_word_count", wc0, 0);
    for (int w = 1; w <= 20; w++) begin
      send(1'b1, 8'h00, 1'b0);
      if (w == 19) chk("rst_relock19", locked0, 0);
      if (w == 20) chk("rst_relock20", locked0, 1);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(199) == 0) set_mode(3'($urandom_range(7)));
      if ($urandom_range(499) == 0) do_reset();
      else send($urandom_range(4) != 0,
                ($urandom_range(29) == 0) ? 8'($urandom) :
                ($urandom_range(9) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00,
                $urandom_range(39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lfsr_prbs_lock_check.md
# lfsr_prbs_lock_check

Runtime-selectable, self-synchronising PRBS checker for DATA_WIDTH-bit parallel data. It supports PRBS7/9/15/23/31 and adds a lock state machine, a per-bit error mask, and saturating error and word counters. It sits on the receive side of link and SERDES loopback tests, opposite the PRBS generator built on the `lfsr` core.

## Interface
- DATA_WIDTH, 8: parallel word width, 1..64.
- LOCK_COUNT, 16: consecutive clean words in HUNT required to lock.
- UNLOCK_ERRORS, 4: consecutive errored words in LOCKED that drop lock.
- COUNT_WIDTH, 32: width of error_count and word_count.
- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high.
- mode  in  3  0 = PRBS7 (x^7+x^6+1), 1 = PRBS9 (x^9+x^5+1), 2 = PRBS15 (x^15+x^14+1), 3 = PRBS23 (x^23+x^18+1), 4..7 = PRBS31 (x^31+x^28+1).
- data_in  in  DATA_WIDTH  received word; bit DATA_WIDTH-1 is first in time.
- data_in_valid  in  1  word qualifier; no backpressure.
- count_clear  in  1  synchronous clear of both counters.
- error_out  out  DATA_WIDTH  per-bit error mask of the checked word.
- error_valid  out  1  qualifies error_out.
- locked  out  1  high in LOCKED state.
- error_count  out  COUNT_WIDTH  errored bits seen while locked, saturating.
- word_count  out  COUNT_WIDTH  words checked while locked, saturating.

## Operation
- History register: 31 bits of received data, shifted MSB-first on every valid word.
- Prediction: predicted bit = h[n1-1] ^ h[n2-1], where n1 and n2 are the mode's tap positions and h[0] is the most recent bit.
- Error bit = received ^ predicted.
- Checking is chained within the word, so later bits use earlier bits of the same word.
- Non-inverted polynomials only.
- States and transitions:
  - FILL: advances after FILL_WORDS = ceil(31/DATA_WIDTH) valid words, independent of mode; error_out is forced to 0 during FILL; goes to HUNT.
  - HUNT: a clean word increments clean_cnt; an errored word resets clean_cnt to 0; at clean_cnt reaching LOCK_COUNT, goes to LOCKED.
  - LOCKED: an errored word increments bad_cnt; a clean word resets bad_cnt to 0; at bad_cnt reaching UNLOCK_ERRORS, goes to HUNT with clean_cnt = 0.
- A word is counted if state was LOCKED when it was accepted.
  - word_count += 1.
  - error_count += popcount(error mask).
- Both counters saturate at 2^COUNT_WIDTH-1 and never wrap.
- Mode change: mode is registered each cycle; a difference from the stored mode forces FILL and clears clean_cnt and bad_cnt. Counters are kept.
  - A valid word in the same cycle as the change is checked under the new mode and counts as fill word 1.
- count_clear: both counters become 0. It beats a simultaneous increment, so that word is not counted.
- No valid word means state, history and counters hold.

## Timing
- Latency is 1 cycle: error_out and error_valid are registered on the edge after the data_in_valid cycle.
- error_valid is high for exactly one cycle per accepted word.
- locked, error_count and word_count update on the same edge as error_valid for the word that caused the change.
- Reset values:
  - state = FILL, history = 0, mode register = 0.
  - locked = 0, error_out = 0, error_valid = 0.
  - error_count = 0, word_count = 0.
- rst mid-operation: all of the above take effect on the next edge, and the input word in that cycle is discarded.
- Back-to-back valid words are sustained at 1 word per clock.

## Structure
- Shared definitions file holds:
  - mode encodings MODE_PRBS7..MODE_PRBS31;
  - tap pairs per mode (7/6, 9/5, 15/14, 23/18, 31/28);
  - state encodings FILL/HUNT/LOCKED.
- One sub-module, lfsr_prbs_predict (combinational): history, data_in and mode in; error mask and next history out.
- Top level holds the FSM, counters and output registers.

## Test plan
All cases use DATA_WIDTH=8, LOCK_COUNT=16, UNLOCK_ERRORS=4.
- Reset, then a continuous PRBS31 stream (seed all ones, mode=4) -> locked rises with word 20's error_valid (4 fill + 16 clean); error_count stays 0; word_count = N−20 after N words.
- While locked, flip one bit -> three error_out bits set across words: at the flip, 28 bits later and 31 bits later. error_count += 3, locked stays 1.
- While locked, 4 words each with errors -> locked falls with the 4th error_valid; counters freeze afterwards. Clean stream resumes -> relock after 16 clean words.
- Locked on PRBS31, switch mode to 0 with a PRBS7 stream -> locked = 0 one cycle later; relock after 4+16 words; counters retain their prior values.
- count_clear in the same cycle as an errored locked word -> both counters read 0 next cycle. With COUNT_WIDTH=4 and repeated errors -> error_count holds at 15.
- Assert rst mid-stream while locked -> next cycle: locked = 0, error_valid = 0, both counters 0; the FILL sequence restarts.
